iwdg_wb_master: RTL
===================

// Module: iwdg_wb_master
// PURPOSE
// Wishbone master that drives the IWDG register slave from the bus-initiator end.
// On a start pulse it programs the IWDG: unlock, prescaler, reload value, start key.
// It then refreshes the watchdog periodically or on request, reading IWDG_ST after each refresh.
// Sits between the system controller and the IWDG slave on the shared Wishbone bus.
// PARAMETERS
// GRL          1             sel_m2s MSB index; sel driven all-ones
// BASE_ADR     32'h0100_0000 IWDG register base; KR +0x0, PR +0x4, RLR +0x8, ST +0xC
// KICK_PERIOD  1024          cycles between automatic refreshes while ARMED (>=2)
// ACK_TIMEOUT  16            max cycles waiting for ack/err/rty per attempt (>=2)
// MAX_RETRY    3             rty_s2m retries per transaction before fault
// PORTS
// clk_m2s     in   1      bus clock
// rst_m2s     in   1      asynchronous reset, active-low
// cfg_start   in   1      pulse: begin configuration sequence (honoured in IDLE only)
// cfg_pr      in   3      prescaler value written to IWDG_PR
// cfg_rlr     in   12     reload value written to IWDG_RLR
// kick_req    in   1      pulse: request immediate refresh (honoured in ARMED only)
// dat_s2m     in   32     read data from slave
// ack_s2m     in   1      slave acknowledge
// err_s2m     in   1      slave error termination
// rty_s2m     in   1      slave retry termination
// dat_m2s     out  32     write data
// adr_m2s     out  32     address
// sel_m2s     out  GRL+1  byte selects
// cyc_m2s     out  1      cycle valid
// stb_m2s     out  1      strobe
// we_m2s      out  1      1 write / 0 read
// lok_m2s     out  1      tied 0
// armed       out  1      watchdog started and being refreshed
// busy        out  1      bus transaction or sequence in progress
// fault       out  1      sticky: err, timeout or retry exhaustion
// st_q        out  2      IWDG_ST[1:0] from last read
// BEHAVIOUR
// - Reset: all outputs 0; st_q=0; state IDLE; counters cleared. Async reset mid-cycle drops cyc/stb at once.
// - States: IDLE, UNLOCK(KR<=16'h5555), WR_PR, WR_RLR, START(KR<=16'hCCCC), ARMED,
//   RELOAD(KR<=16'hAAAA), RD_ST, GAP, FAULT.
// - IDLE --cfg_start--> UNLOCK -> WR_PR -> WR_RLR -> START -> ARMED.
// - cfg_pr/cfg_rlr are sampled into registers on cfg_start; later changes are ignored.
// - ARMED: kick counter loads KICK_PERIOD-1 on entry and counts down.
//   At 0 or on kick_req: RELOAD -> RD_ST -> ARMED (counter reloaded).
// - kick_req and counter==0 in the same cycle: one refresh only.
// - No exit from ARMED except reset; cfg_start ignored there and in all non-IDLE states.
// - Bus cycle, one register per state:
//   - All outputs registered. cyc/stb/adr/we/dat/sel are asserted together and held stable until a response.
//   - Response = ack, err or rty sampled high with cyc&stb high.
//   - The slave needs >=2 cycles to ack; the master simply waits.
// - ack:
//   - Next cycle, cyc/stb go low and stay low for exactly one GAP cycle.
//   - Then the next state begins.
//   - On RD_ST ack, st_q <= dat_s2m[1:0].
// - rty: drop cyc/stb for one cycle, reissue the identical access, increment retry count.
//   After MAX_RETRY retries, the next rty goes to FAULT.
// - err, or ACK_TIMEOUT cycles with no response: go to FAULT.
// - Response priority when several are high: err > ack > rty.
// - FAULT: cyc/stb low, fault=1, armed=0, busy=0; stays until reset.
// - Data width: dat_m2s zero-extended (KR 16 bits, PR 3 bits, RLR 12 bits).
// - sel_m2s = all ones. lok_m2s = 0.
// - busy=1 in every state except IDLE, ARMED (counting) and FAULT.
// - armed=1 from ARMED entry, including RELOAD/RD_ST; cleared only by reset or FAULT.
// TESTING
// - cfg_start, pr=3'd4, rlr=12'h0FF, slave acks in 2 cycles -> writes in order:
//   0x0100_0000=0x5555, 0x0100_0004=0x4, 0x0100_0008=0x0FF, 0x0100_0000=0xCCCC; then armed=1.
// - KICK_PERIOD=8 while armed -> every 8+ cycles: write 0x0100_0000=0xAAAA, then read 0x0100_000C.
//   Slave returns 0x2 -> st_q=2'b10.
// - kick_req asserted on the same cycle the counter hits 0 -> exactly one 0xAAAA write.
// - Slave asserts rty twice on WR_PR, then ack -> three identical accesses with a 1-cycle cyc gap; fault=0.
//   With 4 rty -> fault=1, cyc=0.
// - Slave silent for ACK_TIMEOUT=16 cycles on UNLOCK -> fault=1 on cycle 17, bus released.
//   err_s2m on any access -> fault.
// - rst_m2s low mid-transaction (stb=1) -> cyc/stb/armed/busy=0 immediately.
//   After release, cfg_start reruns the full sequence.

Source files
------------

// File: rtl/iwdg_wb_master.sv
// iwdg_wb_master: Wishbone master that configures the IWDG and keeps it refreshed.
// Each state after the first runs exactly one bus access, and a GAP cycle separates consecutive accesses.
module iwdg_wb_master #(
    parameter int          GRL         = 1,
    parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
    parameter int          KICK_PERIOD = 1024,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          MAX_RETRY   = 3
) (
    input  logic         clk_m2s,
    input  logic         rst_m2s,
    input  logic         cfg_start,
    input  logic [2:0]   cfg_pr,
    input  logic [11:0]  cfg_rlr,
    input  logic         kick_req,
    input  logic [31:0]  dat_s2m,
    input  logic         ack_s2m,
    input  logic         err_s2m,
    input  logic         rty_s2m,
    output logic [31:0]  dat_m2s,
    output logic [31:0]  adr_m2s,
    output logic [GRL:0] sel_m2s,
    output logic         cyc_m2s,
    output logic         stb_m2s,
    output logic         we_m2s,
    output logic         lok_m2s,
    output logic         armed,
    output logic         busy,
    output logic         fault,
    output logic [1:0]   st_q
);
    localparam int KW = $clog2(KICK_PERIOD);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {IDLE, UNLOCK, WR_PR, WR_RLR, START, ARMED, RELOAD, RD_ST, GAP, FAULT} state_t;

    state_t        state, tgt, n;
    logic          iss, bus;
    logic [2:0]    pr_q;
    logic [11:0]   rlr_q;
    logic [KW-1:0] kcnt;
    logic [TW-1:0] tmo;
    logic [RW-1:0] rcnt;
    logic          unused;

    assign lok_m2s = 1'b0;
    assign unused  = ^dat_s2m[31:2];
    assign bus     = state inside {UNLOCK, WR_PR, WR_RLR, START, RELOAD, RD_ST};

    function automatic logic [31:0] adr_of(input state_t s);
        return BASE_ADR + (s == WR_PR ? 32'h4 : s == WR_RLR ? 32'h8 : s == RD_ST ? 32'hC : 32'h0);
    endfunction

    function automatic logic [31:0] dat_of(input state_t s);
        return s == UNLOCK ? 32'h5555 : s == WR_PR ? {29'd0, pr_q} : s == WR_RLR ? {20'd0, rlr_q} :
               s == START ? 32'hCCCC : s == RELOAD ? 32'hAAAA : 32'h0;
    endfunction

    function automatic state_t next_of(input state_t s);
        return s == UNLOCK ? WR_PR : s == WR_PR ? WR_RLR : s == WR_RLR ? START : s == RELOAD ? RD_ST : ARMED;
    endfunction

    // err > ack > rty; a bus state with cyc low is the one-cycle pause before a retry reissue
    always_comb begin
        n   = state;
        iss = 1'b0;
        if (state == IDLE) begin
            iss = cfg_start;
            n   = cfg_start ? UNLOCK : IDLE;
        end else if (state == ARMED) begin
            iss = kick_req || kcnt == '0;
            n   = iss ? RELOAD : ARMED;
        end else if (state == GAP) begin
            iss = tgt != ARMED;
            n   = tgt;
        end else if (bus) begin
            iss = !cyc_m2s;
            n   = !cyc_m2s ? state : err_s2m ? FAULT : ack_s2m ? GAP :
                  rty_s2m ? (rcnt == RW'(MAX_RETRY) ? FAULT : state) :
                  tmo == TW'(ACK_TIMEOUT - 1) ? FAULT : state;
        end
    end

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            state   <= IDLE;
            tgt     <= IDLE;
            pr_q    <= '0;
            rlr_q   <= '0;
            kcnt    <= '0;
            tmo     <= '0;
            rcnt    <= '0;
            dat_m2s <= '0;
            adr_m2s <= '0;
            sel_m2s <= '0;
            cyc_m2s <= 1'b0;
            stb_m2s <= 1'b0;
            we_m2s  <= 1'b0;
            armed   <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            st_q    <= '0;
        end else begin
            if (state == IDLE && cfg_start) begin
                pr_q  <= cfg_pr;
                rlr_q <= cfg_rlr;
            end
            if (state == ARMED && !iss)
                kcnt <= kcnt - 1'b1;
            if (state == GAP && tgt == ARMED)
                kcnt <= KW'(KICK_PERIOD - 1);
            if (bus && cyc_m2s && !err_s2m) begin
                if (ack_s2m) begin
                    tgt  <= next_of(state);
                    rcnt <= '0;
                    if (state == RD_ST)
                        st_q <= dat_s2m[1:0];
                end else if (rty_s2m) begin
                    rcnt    <= rcnt + 1'b1;
                    cyc_m2s <= 1'b0;
                    stb_m2s <= 1'b0;
                end else
                    tmo <= tmo + 1'b1;
            end
            if (iss) begin
                cyc_m2s <= 1'b1;
                stb_m2s <= 1'b1;
                adr_m2s <= adr_of(n);
                dat_m2s <= dat_of(n);
                we_m2s  <= n != RD_ST;
                sel_m2s <= '1;
                tmo     <= '0;
            end else if (n == GAP || n == FAULT) begin
                cyc_m2s <= 1'b0;
                stb_m2s <= 1'b0;
            end
            state <= n;
            busy  <= !(n inside {IDLE, ARMED, FAULT});
            armed <= (armed || n == ARMED) && n != FAULT;
            fault <= n == FAULT;
        end
    end
endmodule
